// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage between pc_reg and the IF/ID latch.
// A direct-mapped cache (one 32-bit instruction per line) serves hits in one
// cycle. A miss is filled one byte at a time from the memory port. After the
// fill, the stage drops back to IDLE, where the next lookup hits.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   pc_i / pc_o         fetch PC in; same PC out to the branch predictor (comb)
//   pred_i              predictor taken bit for pc_o
//   stall_i, flush_i    IF/ID back-pressure; misprediction flush from EX
//   pc_stall_o          comb; tells pc_reg to hold pc_i
//   mem_req_o/addr_o    registered byte read request and its byte address
//   mem_ready_i/data_i  returned byte and its valid strobe
//   if_valid_o, if_inst_o, if_pc_o, if_pred_o   registered payload to IF/ID
module if_fetch #(
    parameter int unsigned ICACHE_ENTRIES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o,
    input  logic        pred_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        pc_stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        if_pred_o
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IDX_W   = $clog2(ICACHE_ENTRIES);
    localparam int unsigned TAG_LSB = IDX_W + 2;
    localparam int unsigned TAG_W   = XLEN - TAG_LSB;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned BUF_W   = 24;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic                  mem_req_d;
    logic [XLEN-1:0]       mem_addr_d;
    logic                  valid_d;
    logic [XLEN-1:0]       inst_d;
    logic [XLEN-1:0]       ipc_d;
    logic                  pred_d;
    logic                  fill_en;
    logic [XLEN-1:0]       fill_word;

    logic [ICACHE_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]          tag_q  [ICACHE_ENTRIES];
    logic [XLEN-1:0]           data_q [ICACHE_ENTRIES];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag_in;
    logic                  hit;

    // Cache lookup on the current PC
    assign idx       = pc_i[TAG_LSB-1:2];
    assign tag_in    = pc_i[XLEN-1:TAG_LSB];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag_in);
    assign pc_o      = pc_i;
    // The 4th byte completes the little-endian word directly from the port
    assign fill_word = {mem_data_i, buf_q};

    // Next-state, payload and PC-hold logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        mem_req_d  = mem_req_o;
        mem_addr_d = mem_addr_o;
        valid_d    = if_valid_o;
        inst_d     = if_inst_o;
        ipc_d      = if_pc_o;
        pred_d     = if_pred_o;
        fill_en    = 1'b0;
        pc_stall_o = 1'b1;

        if (flush_i) begin
            // Drop any partial fill and let pc_reg take the redirect
            state_d    = IDLE;
            cnt_d      = '0;
            valid_d    = 1'b0;
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
            pc_stall_o = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!stall_i) begin
                        if (hit) begin
                            pc_stall_o = 1'b0;
                            valid_d    = 1'b1;
                            inst_d     = data_q[idx];
                            ipc_d      = pc_i;
                            pred_d     = pred_i;
                        end else begin
                            state_d    = FETCH;
                            cnt_d      = '0;
                            valid_d    = 1'b0;
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_i;
                        end
                    end
                end
                FETCH: begin
                    if (mem_ready_i) begin
                        unique case (cnt_q)
                            2'd0: buf_d[7:0]   = mem_data_i;
                            2'd1: buf_d[15:8]  = mem_data_i;
                            2'd2: buf_d[23:16] = mem_data_i;
                            default: fill_en   = 1'b1;
                        endcase
                        if (cnt_q == 2'd3) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            mem_req_d  = 1'b0;
                            mem_addr_d = '0;
                        end else begin
                            cnt_d      = cnt_q + CNT_W'(1);
                            // pc_i is held throughout FETCH, so this tracks pc_i+cnt
                            mem_addr_d = pc_i + XLEN'(cnt_q) + XLEN'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            if_valid_o <= 1'b0;
            if_inst_o  <= '0;
            if_pc_o    <= '0;
            if_pred_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            mem_req_o  <= mem_req_d;
            mem_addr_o <= mem_addr_d;
            if_valid_o <= valid_d;
            if_inst_o  <= inst_d;
            if_pc_o    <= ipc_d;
            if_pred_o  <= pred_d;
        end
    end

    // Line valid bits; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays; meaningless while the line's valid bit is clear
    always_ff @(posedge clk) begin
        if (rst && fill_en) begin
            tag_q[idx]  <= tag_in;
            data_q[idx] <= fill_word;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch. Memory is modelled as a byte map with a few overrides.
// The cache model tracks which line holds which tag.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] pc_o;
    logic        pred_i, stall_i, flush_i;
    logic        pc_stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o, if_pc_o;
    logic        if_pred_o;

    int checks = 0;
    int failures = 0;

    bit          mvalid [128];
    logic [22:0] mtag   [128];
    logic [7:0]  mem_ov [logic [31:0]];

    logic        exp_valid;
    logic [31:0] exp_inst, exp_pc;
    logic        exp_pred;

    if_fetch dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_o(pc_o), .pred_i(pred_i),
        .stall_i(stall_i), .flush_i(flush_i), .pc_stall_o(pc_stall_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
        .if_valid_o(if_valid_o), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o),
        .if_pred_o(if_pred_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [31:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mvalid[i] = 1'b0;
        exp_valid = 1'b0; exp_inst = '0; exp_pc = '0; exp_pred = 1'b0;
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        return mvalid[pc[8:2]] && (mtag[pc[8:2]] == pc[31:9]);
    endfunction

    // One complete fetch of pc; checks the miss path when the model predicts a miss.
    task automatic access(input logic [31:0] pc, input logic pred, input bit rnd, output int lat);
        bit h;
        int k;
        h = model_hit(pc);
        lat = 0;
        pc_i = pc; pred_i = pred; stall_i = 1'b0; flush_i = 1'b0;
        mem_ready_i = rnd ? 1'($urandom) : 1'b0;
        mem_data_i = 8'($urandom);
        #1;
        chk("pc_o", pc_o, pc);
        chk("pc_stall_lookup", 32'(pc_stall_o), 32'(!h));
        if (!h) begin
            step(); lat++;
            chk("req_start", 32'(mem_req_o), 32'd1);
            chk("valid_miss", 32'(if_valid_o), 32'd0);
            k = 0;
            for (int c = 0; c < 64 && k < 4; c++) begin
                chk("mem_addr", mem_addr_o, pc + 32'(k));
                chk("pc_stall_fetch", 32'(pc_stall_o), 32'd1);
                mem_ready_i = rnd ? 1'($urandom) : 1'b1;
                mem_data_i  = mem_ready_i ? mb(pc + 32'(k)) : 8'($urandom);
                step(); lat++;
                if (mem_ready_i) k++;
            end
            if (k < 4) chk("fetch_timeout", 32'(k), 32'd4);
            mem_ready_i = 1'b0;
            chk("req_done", 32'(mem_req_o), 32'd0);
            chk("addr_idle", mem_addr_o, 32'd0);
            mvalid[pc[8:2]] = 1'b1;
            mtag[pc[8:2]]   = pc[31:9];
            #1;
            chk("pc_stall_after_fill", 32'(pc_stall_o), 32'd0);
        end
        step(); lat++;
        exp_valid = 1'b1; exp_inst = word(pc); exp_pc = pc; exp_pred = pred;
        chk("if_valid", 32'(if_valid_o), 32'd1);
        chk("if_inst", if_inst_o, exp_inst);
        chk("if_pc", if_pc_o, exp_pc);
        chk("if_pred", 32'(if_pred_o), 32'(exp_pred));
    endtask

    // Hold pc_i under stall for n cycles; outputs must not move.
    task automatic stall_cycles(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) begin
            pc_i = pc; stall_i = 1'b1; flush_i = 1'b0;
            mem_ready_i = 1'($urandom); mem_data_i = 8'($urandom);
            #1;
            chk("pc_stall_stall", 32'(pc_stall_o), 32'd1);
            step();
            chk("hold_valid", 32'(if_valid_o), 32'(exp_valid));
            chk("hold_inst", if_inst_o, exp_inst);
            chk("hold_pc", if_pc_o, exp_pc);
            chk("hold_pred", 32'(if_pred_o), 32'(exp_pred));
        end
        stall_i = 1'b0;
    endtask

    // Start a miss at pc, deliver nbytes, then flush while the next byte arrives.
    task automatic flush_fetch(input logic [31:0] pc, input int nbytes);
        pc_i = pc; pred_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0;
        step();
        for (int k = 0; k < nbytes; k++) begin
            mem_ready_i = 1'b1; mem_data_i = mb(pc + 32'(k));
            step();
        end
        mem_ready_i = 1'b1; mem_data_i = mb(pc + 32'(nbytes)); flush_i = 1'b1;
        #1;
        chk("pc_stall_flush", 32'(pc_stall_o), 32'd0);
        step();
        flush_i = 1'b0; mem_ready_i = 1'b0;
        exp_valid = 1'b0;
        chk("flush_valid", 32'(if_valid_o), 32'd0);
        chk("flush_req", 32'(mem_req_o), 32'd0);
        chk("flush_addr", mem_addr_o, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] pc;
        rst = 1'b0; pc_i = '0; pred_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        mem_ready_i = 1'b0; mem_data_i = '0;
        mem_ov[32'h1000] = 8'h13; mem_ov[32'h1001] = 8'h05;
        mem_ov[32'h1002] = 8'h00; mem_ov[32'h1003] = 8'h00;
        model_reset();
        step(); step();
        chk("rst_valid", 32'(if_valid_o), 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_pred", 32'(if_pred_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        rst = 1'b1;

        // Cold miss at 0x1000, ready every cycle
        access(32'h1000, 1'b0, 1'b0, lat);
        chk("cold_latency", 32'(lat), 32'd6);
        chk("cold_inst_const", if_inst_o, 32'h0000_0513);

        // Warm hit stream
        access(32'h1004, 1'b0, 1'b0, lat);
        for (int i = 0; i < 4; i++) begin
            access(32'h1000, 1'b0, 1'b1, lat);
            chk("hit_latency", 32'(lat), 32'd1);
            access(32'h1004, 1'b1, 1'b1, lat);
            chk("hit_latency", 32'(lat), 32'd1);
        end

        // Stall on a hit, then release
        access(32'h1000, 1'b1, 1'b0, lat);
        stall_cycles(32'h1004, 3);
        access(32'h1004, 1'b0, 1'b0, lat);
        chk("release_latency", 32'(lat), 32'd1);

        // Flush after byte 2, and on the completing 4th byte
        flush_fetch(32'h2000, 2);
        access(32'h2000, 1'b0, 1'b0, lat);
        chk("refetch_latency", 32'(lat), 32'd6);
        flush_fetch(32'h2400, 3);
        access(32'h2400, 1'b1, 1'b1, lat);

        // Tag conflict between 0x0000 and 0x0200
        for (int i = 0; i < 3; i++) begin
            access(32'h0000_0000, 1'b0, 1'b0, lat);
            chk("conflict_latency", 32'(lat), 32'd6);
            access(32'h0000_0200, 1'b1, 1'b0, lat);
            chk("conflict_latency", 32'(lat), 32'd6);
        end

        // Reset while byte 1 is returned
        pc_i = 32'h3000; pred_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        step();
        mem_ready_i = 1'b1; mem_data_i = mb(32'h3000); rst = 1'b0;
        step();
        model_reset();
        chk("midrst_req", 32'(mem_req_o), 32'd0);
        chk("midrst_valid", 32'(if_valid_o), 32'd0);
        chk("midrst_addr", mem_addr_o, 32'd0);
        rst = 1'b1; mem_ready_i = 1'b0;
        access(32'h3000, 1'b0, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'd6);
        access(32'h1000, 1'b0, 1'b0, lat);
        chk("post_rst_1000_miss", 32'(lat), 32'd6);

        // Random traffic over a small address set so hits and conflicts mix
        for (int i = 0; i < 200; i++) begin
            pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
                 | (32'($urandom_range(0, 1)) << 28);
            if ($urandom_range(0, 7) == 0) stall_cycles(pc, int'($urandom_range(1, 2)));
            if ($urandom_range(0, 15) == 0) flush_fetch(pc, int'($urandom_range(0, 3)));
            access(pc, 1'($urandom), 1'b1, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V core, between pc_reg and the IF/ID latch. Each cycle it presents the current PC to the branch predictor, serves the instruction from a direct-mapped instruction cache, or on a miss assembles it from the byte-wide memory port. It forwards instruction, PC and prediction bit to IF/ID, and holds pc_reg while a miss is outstanding.

## Interface
- ICACHE_ENTRIES, 128: cache lines of one 32-bit instruction each; index = pc[8:2], tag = pc[31:9].
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- pc_i  in  32  fetch address from pc_reg; always word-aligned.
- pc_o  out  32  address sent to the predictor; equals pc_i combinationally.
- pred_i  in  1  predictor's taken bit for pc_o.
- stall_i  in  1  downstream back-pressure from IF/ID.
- flush_i  in  1  misprediction flush from EX.
- pc_stall_o  out  1  combinational; 1 = pc_reg must hold pc_i.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address of the request.
- mem_ready_i  in  1  mem_data_i valid for the current request.
- mem_data_i  in  8  returned byte.
- if_valid_o  out  1  registered; instruction outputs valid.
- if_inst_o  out  32  registered instruction.
- if_pc_o  out  32  registered PC of if_inst_o.
- if_pred_o  out  1  registered predictor bit captured with the instruction.

## Operation
- Cache storage: per line, a valid bit, a 23-bit tag and a 32-bit data word. Hit = valid[idx] && tag[idx]==pc_i[31:9].
- States:
  - IDLE: lookup state.
  - FETCH: byte counter cnt in 0..3.
- IDLE, hit, stall_i=0, flush_i=0:
  - Next edge: if_valid_o<=1, if_inst_o<=data[idx], if_pc_o<=pc_i, if_pred_o<=pred_i.
  - pc_stall_o=0, so pc_reg advances on the same edge.
- IDLE, miss, stall_i=0, flush_i=0:
  - pc_stall_o=1.
  - Next edge: state<=FETCH, cnt<=0, if_valid_o<=0.
- FETCH:
  - mem_req_o=1, mem_addr_o=pc_i+cnt, pc_stall_o=1.
  - On an edge with mem_ready_i=1: buf[8*cnt+:8]<=mem_data_i (little-endian), cnt<=cnt+1.
  - On the 4th byte (cnt==3): write the line (valid=1, tag, data = assembled word) and return to IDLE. The next IDLE cycle hits and emits the instruction.
- stall_i=1, no flush:
  - pc_stall_o=1; all if_* outputs hold.
  - A fetch in progress continues; on completion it fills the cache and waits in IDLE.
- flush_i=1: highest priority.
  - Next edge: if_valid_o<=0, state<=IDLE, cnt<=0.
  - Partial buffer is discarded; the cache is not written. A completing 4th byte in the same cycle is also dropped.
  - pc_stall_o=0 that cycle so pc_reg loads the corrected PC.
- Outside FETCH: mem_req_o=0, mem_addr_o=0.
- Arithmetic: pc_i+cnt is 32-bit and wraps modulo 2^32.
- The cache is never invalidated except by reset (no self-modifying code is supported).

## Timing
- Reset (rst==0 at an edge):
  - Outputs: if_valid_o=0, if_inst_o=0, if_pc_o=0, if_pred_o=0, mem_req_o=0.
  - State: state=IDLE, cnt=0, all valid bits cleared.
  - Reset mid-FETCH aborts with no cache write.
  - Reset has priority over flush_i and stall_i.
- Hit latency: 1 cycle from pc_i to if_valid_o; sustained throughput is 1 instruction per cycle.
- Miss latency: 1 cycle to enter FETCH, plus one cycle per accepted byte (minimum 4), plus 1 cycle for the IDLE hit. Minimum is 6 cycles pc_i→if_valid_o.
- mem_ready_i is ignored outside FETCH. mem_addr_o changes only on an edge where a byte is accepted.
- pc_o and pc_stall_o are combinational from pc_i, state, hit, stall_i and flush_i. No other output is combinational.
- Two PCs with the same pc[8:2] and a different tag evict each other. Each access is a miss.

## Test plan
- Cold miss: pc_i=0x1000, memory bytes 13,05,00,00 with ready every cycle → mem_addr_o 0x1000..0x1003. 6 cycles later: if_valid_o=1, if_inst_o=0x00000513, if_pc_o=0x1000.
- Warm hit stream: after filling 0x1000/0x1004, stepping pc_i gives one valid instruction per cycle and pc_stall_o=0 throughout. With pred_i=1 at 0x1004, if_pred_o=1 for that instruction.
- Flush mid-fetch: flush_i=1 after byte 2 at 0x2000 → if_valid_o=0 and state IDLE next edge. A later access to 0x2000 misses again and issues 4 fresh requests.
- Stall: stall_i=1 for 3 cycles on a hit → if_* outputs stay constant and pc_stall_o=1. Release → the next instruction appears 1 cycle later.
- Tag conflict: alternate pc_i 0x0000 and 0x0200 → every access misses, and each returns the correct distinct word.
- Reset mid-fetch: rst=0 during byte 1 → mem_req_o=0 and if_valid_o=0 after the edge. A later access to the same PC misses.
